// File: rtl/lc3_writeback_rf_if.sv
// rtl/lc3_writeback_rf_if.sv - writeback/register-file bus between pipeline stages and the RF
interface lc3_writeback_rf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    // write side, driven by memaccess/execute
    logic              enable_writeback;
    logic [1:0]        W_control_in;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] memout;
    logic [DATA_W-1:0] pcout;
    logic [DATA_W-1:0] npc;
    logic [ADDR_W-1:0] dr;

    // read side, driven by decode/execute
    logic [ADDR_W-1:0] sr1;
    logic [ADDR_W-1:0] sr2;

    // results returned by the register file
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [2:0]        psr;
    logic              wb_ready;

    modport master (
        output enable_writeback, W_control_in, aluout, memout, pcout, npc, dr, sr1, sr2,
        input  VSR1, VSR2, psr, wb_ready
    );

    modport slave (
        input  enable_writeback, W_control_in, aluout, memout, pcout, npc, dr, sr1, sr2,
        output VSR1, VSR2, psr, wb_ready
    );
endinterface

// File: rtl/lc3_writeback_rf.sv
// rtl/lc3_writeback_rf.sv - LC3 writeback stage: source select, register file, N/Z/P codes, clear sweep
module lc3_writeback_rf #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 8,
    parameter int BYPASS    = 0
) (
    input  logic              clock,
    input  logic              reset,
    lc3_writeback_rf_if.slave wb
);
    // Register index width follows the register count; never overridden.
    localparam int ADDR_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    // One extra bit so the range check also works when REG_COUNT is a power of two.
    localparam logic [ADDR_W:0]   LP_COUNT = (ADDR_W + 1)'(REG_COUNT);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(REG_COUNT - 1);

    // Two-state controller: INIT sweeps zeros through the array, RUN accepts writes.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] CC_NEG  = 3'b100;
    localparam logic [2:0] CC_ZERO = 3'b010;
    localparam logic [2:0] CC_POS  = 3'b001;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [2:0]        r_psr;

    // The array has no reset of its own; the INIT sweep is what clears it.
    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic              w_in_run;
    logic              w_dr_ok;
    logic              w_sr1_ok;
    logic              w_sr2_ok;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wb_data;
    logic [2:0]        w_cc;
    logic [DATA_W-1:0] w_vsr1;
    logic [DATA_W-1:0] w_vsr2;

    assign w_in_run = (r_state == ST_RUN);

    // Index checks matter only for non-power-of-two counts, where some codes name no register.
    assign w_dr_ok  = ({1'b0, wb.dr}  < LP_COUNT);
    assign w_sr1_ok = ({1'b0, wb.sr1} < LP_COUNT);
    assign w_sr2_ok = ({1'b0, wb.sr2} < LP_COUNT);

    // A write is taken only in RUN; requests seen during INIT are dropped, not held.
    assign w_wr_en = w_in_run && wb.enable_writeback && w_dr_ok;

    // Writeback source select; only the chosen input can reach the result.
    always_comb begin
        w_wb_data = '0;
        case (wb.W_control_in)
            2'd0:    w_wb_data = wb.aluout;
            2'd1:    w_wb_data = wb.memout;
            2'd2:    w_wb_data = wb.pcout;
            default: w_wb_data = wb.npc;
        endcase
    end

    // Condition codes derived from the value being written.
    always_comb begin
        w_cc = CC_POS;
        if (w_wb_data[DATA_W-1]) begin
            w_cc = CC_NEG;
        end else if (w_wb_data == '0) begin
            w_cc = CC_ZERO;
        end
    end

    // Controller state, clear index and psr; reset restarts the sweep from entry 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
            r_psr     <= 3'b000;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Leave INIT on the same edge that clears the last entry.
                    if (r_clr_idx == LP_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    if (w_wr_en) begin
                        r_psr <= w_cc;
                    end
                end
            endcase
        end
    end

    // Register array update: zero fill during INIT, selected source during RUN.
    always_ff @(posedge clock) begin
        if (r_state == ST_INIT) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[wb.dr] <= w_wb_data;
        end
    end

    // Read port 1: zero while clearing, optional same-cycle bypass, else stored value.
    always_comb begin
        w_vsr1 = '0;
        if (!w_in_run) begin
            w_vsr1 = '0;
        end else if ((BYPASS != 0) && w_wr_en && (wb.sr1 == wb.dr)) begin
            w_vsr1 = w_wb_data;
        end else if (w_sr1_ok) begin
            w_vsr1 = r_regs[wb.sr1];
        end
    end

    // Read port 2: same rules as port 1, bypass decided independently.
    always_comb begin
        w_vsr2 = '0;
        if (!w_in_run) begin
            w_vsr2 = '0;
        end else if ((BYPASS != 0) && w_wr_en && (wb.sr2 == wb.dr)) begin
            w_vsr2 = w_wb_data;
        end else if (w_sr2_ok) begin
            w_vsr2 = r_regs[wb.sr2];
        end
    end

    assign wb.VSR1     = w_vsr1;
    assign wb.VSR2     = w_vsr2;
    assign wb.psr      = r_psr;
    assign wb.wb_ready = w_in_run;
endmodule

// File: tb/tb_lc3_writeback_rf.sv
// tb/tb_lc3_writeback_rf.sv - scoreboard bench for lc3_writeback_rf (8x16 plain, 8x16 bypass, 6x32)
module tb_lc3_writeback_rf;
    localparam int F_V1  = 0;
    localparam int F_V2  = 1;
    localparam int F_PSR = 2;
    localparam int F_RDY = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lc3_writeback_rf_if #(.DATA_W(16), .ADDR_W(3)) if_a ();
    lc3_writeback_rf_if #(.DATA_W(16), .ADDR_W(3)) if_b ();
    lc3_writeback_rf_if #(.DATA_W(32), .ADDR_W(3)) if_c ();

    lc3_writeback_rf #(.DATA_W(16), .REG_COUNT(8), .BYPASS(0)) dut_a (.clock(clk), .reset(rst_n), .wb(if_a));
    lc3_writeback_rf #(.DATA_W(16), .REG_COUNT(8), .BYPASS(1)) dut_b (.clock(clk), .reset(rst_n), .wb(if_b));
    lc3_writeback_rf #(.DATA_W(32), .REG_COUNT(6), .BYPASS(0)) dut_c (.clock(clk), .reset(rst_n), .wb(if_c));

    typedef struct {
        int          dut;
        int          fld;
        logic [63:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t    sb_q[$];
    sb_item_t    mon_it;
    logic [63:0] mon_act;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [63:0] actual(int d, int f);
        logic [63:0] v;
        v = '0;
        case (d)
            0: case (f)
                   F_V1:    v = 64'(if_a.VSR1);
                   F_V2:    v = 64'(if_a.VSR2);
                   F_PSR:   v = 64'(if_a.psr);
                   default: v = 64'(if_a.wb_ready);
               endcase
            1: case (f)
                   F_V1:    v = 64'(if_b.VSR1);
                   F_V2:    v = 64'(if_b.VSR2);
                   F_PSR:   v = 64'(if_b.psr);
                   default: v = 64'(if_b.wb_ready);
               endcase
            default: case (f)
                   F_V1:    v = 64'(if_c.VSR1);
                   F_V2:    v = 64'(if_c.VSR2);
                   F_PSR:   v = 64'(if_c.psr);
                   default: v = 64'(if_c.wb_ready);
               endcase
        endcase
        return v;
    endfunction

    // Monitor: compares every pending expectation against the outputs the DUTs present this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_it  = sb_q.pop_front();
            mon_act = actual(mon_it.dut, mon_it.fld);
            checks++;
            if (mon_act !== mon_it.exp) begin
                failures++;
                $display("FAIL %s dut=%0d actual=%h required=%h", mon_it.name, mon_it.dut, mon_act, mon_it.exp);
            end
        end
    end

    task automatic expect_v(input int d, input int f, input logic [63:0] v, input string n);
        sb_item_t it;
        it.dut  = d;
        it.fld  = f;
        it.exp  = v;
        it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_a.enable_writeback = 0; if_a.W_control_in = 0; if_a.aluout = 0; if_a.memout = 0;
        if_a.pcout = 0; if_a.npc = 0; if_a.dr = 0; if_a.sr1 = 0; if_a.sr2 = 0;
        if_b.enable_writeback = 0; if_b.W_control_in = 0; if_b.aluout = 0; if_b.memout = 0;
        if_b.pcout = 0; if_b.npc = 0; if_b.dr = 0; if_b.sr1 = 0; if_b.sr2 = 0;
        if_c.enable_writeback = 0; if_c.W_control_in = 0; if_c.aluout = 0; if_c.memout = 0;
        if_c.pcout = 0; if_c.npc = 0; if_c.dr = 0; if_c.sr1 = 0; if_c.sr2 = 0;
    endtask

    logic [15:0] ss_val [4];
    logic [2:0]  ss_psr [4];

    initial begin
        ss_val = '{16'h0001, 16'h8000, 16'h0000, 16'h3001};
        ss_psr = '{3'b001, 3'b100, 3'b010, 3'b001};
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            expect_v(d, F_PSR, 64'h0, "rst_psr");
            expect_v(d, F_RDY, 64'h0, "rst_ready");
        end
        step();
        rst_n = 1'b1;

        // INIT: ready low for REG_COUNT cycles; writes ignored; reads forced to zero
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                if_a.enable_writeback = 1; if_a.W_control_in = 0; if_a.dr = 3; if_a.aluout = 16'h1234;
                if_b.enable_writeback = 1; if_b.W_control_in = 0; if_b.dr = 3; if_b.aluout = 16'h1234;
            end
            if_a.sr1 = 3; if_b.sr1 = 3; if_b.sr2 = 3;
            expect_v(0, F_RDY, 64'h0, "init_ready_a");
            expect_v(0, F_PSR, 64'h0, "init_psr_a");
            expect_v(0, F_V1,  64'h0, "init_vsr1_forced_a");
            expect_v(1, F_V1,  64'h0, "init_vsr1_forced_b");
            expect_v(1, F_V2,  64'h0, "init_vsr2_forced_b");
            expect_v(2, F_RDY, (c >= 6) ? 64'h1 : 64'h0, "init_ready_c");
            step();
            if_a.enable_writeback = 0;
            if_b.enable_writeback = 0;
        end
        expect_v(0, F_RDY, 64'h1, "run_ready_a");
        expect_v(1, F_RDY, 64'h1, "run_ready_b");

        // every entry cleared, including the one targeted during INIT
        for (int i = 0; i < 8; i++) begin
            if_a.sr1 = 3'(i);
            if_a.sr2 = 3'(7 - i);
            expect_v(0, F_V1,  64'h0, "clear_vsr1");
            expect_v(0, F_V2,  64'h0, "clear_vsr2");
            expect_v(0, F_PSR, 64'h0, "clear_psr");
            step();
        end

        // source select into r1, one write per cycle, checked the cycle after each write
        if_a.aluout = 16'h0001; if_a.memout = 16'h8000; if_a.pcout = 16'h0000; if_a.npc = 16'h3001;
        if_a.dr = 1; if_a.sr1 = 1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                if_a.enable_writeback = 1;
                if_a.W_control_in = 2'(k);
            end else begin
                if_a.enable_writeback = 0;
            end
            if (k > 0) begin
                expect_v(0, F_V1,  64'(ss_val[k-1]), "srcsel_vsr1");
                expect_v(0, F_PSR, 64'(ss_psr[k-1]), "srcsel_psr");
            end
            step();
        end
        idle();

        // same-cycle read of r5 while writing it
        if_a.enable_writeback = 1; if_a.W_control_in = 0; if_a.dr = 5; if_a.sr1 = 5; if_a.sr2 = 5;
        if_a.aluout = 16'hBEEF; if_a.memout = 16'h1111; if_a.pcout = 16'h2222; if_a.npc = 16'h3333;
        if_b.enable_writeback = 1; if_b.W_control_in = 0; if_b.dr = 5; if_b.sr1 = 5; if_b.sr2 = 5;
        if_b.aluout = 16'hBEEF; if_b.memout = 16'h1111; if_b.pcout = 16'h2222; if_b.npc = 16'h3333;
        expect_v(0, F_V1,  64'h0,    "nobypass_vsr1_same");
        expect_v(0, F_V2,  64'h0,    "nobypass_vsr2_same");
        expect_v(1, F_V1,  64'hBEEF, "bypass_vsr1_same");
        expect_v(1, F_V2,  64'hBEEF, "bypass_vsr2_same");
        expect_v(1, F_PSR, 64'h0,    "bypass_psr_latency");
        step();
        if_a.enable_writeback = 0;
        if_b.enable_writeback = 1; if_b.W_control_in = 3; if_b.sr2 = 4;
        expect_v(0, F_V1,  64'hBEEF, "nobypass_vsr1_next");
        expect_v(0, F_V2,  64'hBEEF, "nobypass_vsr2_next");
        expect_v(0, F_PSR, 64'h4,    "nobypass_psr_next");
        expect_v(1, F_V1,  64'h3333, "bypass_vsr1_npc");
        expect_v(1, F_V2,  64'h0,    "bypass_vsr2_indep");
        expect_v(1, F_PSR, 64'h4,    "bypass_psr_next");
        step();
        if_b.enable_writeback = 0;
        expect_v(1, F_V1,  64'h3333, "bypass_vsr1_stored");
        expect_v(1, F_PSR, 64'h1,    "bypass_psr_npc");
        step();
        idle();

        // REG_COUNT=6, DATA_W=32: out-of-range destination is dropped
        if_c.enable_writeback = 1; if_c.W_control_in = 0; if_c.dr = 0; if_c.aluout = 32'h1;
        step();
        if_c.W_control_in = 1; if_c.dr = 7; if_c.memout = 32'hFFFF_FFFF;
        if_c.sr1 = 7; if_c.sr2 = 0;
        expect_v(2, F_PSR, 64'h1, "c_psr_pos");
        expect_v(2, F_V2,  64'h1, "c_vsr2_r0");
        step();
        if_c.dr = 5;
        expect_v(2, F_PSR, 64'h1, "c_oor_psr_hold");
        expect_v(2, F_V1,  64'h0, "c_oor_vsr1");
        step();
        if_c.enable_writeback = 0; if_c.dr = 6; if_c.sr1 = 5; if_c.sr2 = 6;
        expect_v(2, F_PSR, 64'h4,          "c_r5_psr_neg");
        expect_v(2, F_V1,  64'hFFFF_FFFF,  "c_r5_vsr1");
        expect_v(2, F_V2,  64'h0,          "c_oor_vsr2");
        step();
        idle();

        // reset in RUN discards register contents and restarts the sweep
        if_a.enable_writeback = 1; if_a.W_control_in = 0; if_a.dr = 2; if_a.aluout = 16'h00AA;
        step();
        if_a.enable_writeback = 0; if_a.sr1 = 2;
        expect_v(0, F_V1,  64'h00AA, "pre_reset_vsr1");
        expect_v(0, F_PSR, 64'h1,    "pre_reset_psr");
        step();
        rst_n = 1'b0;
        expect_v(0, F_PSR, 64'h0, "midrun_reset_psr");
        expect_v(0, F_RDY, 64'h0, "midrun_reset_ready");
        expect_v(2, F_RDY, 64'h0, "midrun_reset_ready_c");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            expect_v(0, F_RDY, 64'h0, "reinit_ready");
            expect_v(0, F_V1,  64'h0, "reinit_vsr1");
            step();
        end
        expect_v(0, F_RDY, 64'h1, "rerun_ready");
        expect_v(0, F_V1,  64'h0, "rerun_r2_cleared");
        expect_v(0, F_PSR, 64'h0, "rerun_psr");
        step();

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
